// File: rtl/riscv_soft_decode_stage_pkg.sv
// rtl/riscv_soft_decode_stage_pkg.sv - immediate-select codes, opcodes and the opcode classifier
package riscv_soft_decode_stage_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        imm_sel_e imm_sel;
        logic     uses_imm;
        logic     rd_wen;
        logic     illegal;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    // Every legal opcode ends in 2'b11, so compressed/16-bit encodings fall into the default arm.
    function automatic dec_t decode_inst(input logic [31:0] inst);
        dec_t d;
        d.imm_sel  = IMM_I;
        d.uses_imm = 1'b0;
        d.rd_wen   = 1'b0;
        d.illegal  = 1'b0;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.imm_sel  = IMM_U;
                d.uses_imm = 1'b1;
                d.rd_wen   = 1'b1;
            end
            OPC_JAL: begin
                d.imm_sel  = IMM_J;
                d.uses_imm = 1'b1;
                d.rd_wen   = 1'b1;
            end
            OPC_BRANCH: begin
                d.imm_sel  = IMM_B;
            end
            OPC_STORE: begin
                d.imm_sel  = IMM_S;
                d.uses_imm = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
                d.uses_imm = 1'b1;
                d.rd_wen   = 1'b1;
            end
            OPC_OP: begin
                d.rd_wen   = 1'b1;
            end
            default: begin
                d.illegal  = 1'b1;
            end
        endcase
        if (inst[11:7] == 5'd0) begin
            d.rd_wen = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/riscv_soft_decode_stage_if.sv
// rtl/riscv_soft_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface riscv_soft_decode_stage_if #(
    parameter int XPR_LEN = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_inst;
    logic [XPR_LEN-1:0] in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic [XPR_LEN-1:0] out_pc;
    logic [2:0]         out_imm_sel;
    logic               out_uses_imm;
    logic               out_rd_wen;
    logic               out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc,
        output out_imm_sel, out_uses_imm, out_rd_wen, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc,
        input  out_imm_sel, out_uses_imm, out_rd_wen, out_illegal
    );
endinterface

// File: rtl/riscv_soft_decode_stage_skid_buffer.sv
// rtl/riscv_soft_decode_stage_skid_buffer.sv - two-entry registered skid buffer with flush
module riscv_soft_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;
    logic             main_free;

    // in_ready depends only on registered state, breaking the out_ready -> in_ready path.
    assign in_ready_o  = !skid_valid_q;
    assign in_fire     = in_valid_i && !skid_valid_q;
    assign main_free   = !main_valid_q || out_ready_i;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_data_d = in_data_i;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/riscv_soft_decode_stage.sv
// rtl/riscv_soft_decode_stage.sv - decode stage: opcode classification ahead of a skid-buffered register
module riscv_soft_decode_stage
    import riscv_soft_decode_stage_pkg::*;
#(
    parameter int XPR_LEN = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    riscv_soft_decode_stage_if.slave   bus
);
    localparam int PKT_W = 32 + XPR_LEN + DEC_W;

    dec_t             dec_in;
    dec_t             dec_out;
    logic [PKT_W-1:0] pkt_in;
    logic [PKT_W-1:0] pkt_out;
    logic             out_valid;
    logic             in_ready;

    always_comb begin
        dec_in = decode_inst(bus.in_inst);
    end

    assign pkt_in = {bus.in_inst, bus.in_pc, dec_in};

    riscv_soft_skid_buffer #(
        .WIDTH (PKT_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (pkt_in),
        .out_valid_o (out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (pkt_out)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign {bus.out_inst, bus.out_pc, dec_out} = pkt_out;
    assign bus.out_imm_sel  = dec_out.imm_sel;
    assign bus.out_uses_imm = dec_out.uses_imm;
    assign bus.out_rd_wen   = dec_out.rd_wen;
    assign bus.out_illegal  = dec_out.illegal;

endmodule

// File: tb/tb_riscv_soft_decode_stage.sv
// tb/tb_riscv_soft_decode_stage.sv - directed self-checking bench for riscv_soft_decode_stage
module tb_riscv_soft_decode_stage;
    localparam logic [2:0] SEL_I = 3'd0;
    localparam logic [2:0] SEL_S = 3'd1;
    localparam logic [2:0] SEL_B = 3'd2;
    localparam logic [2:0] SEL_U = 3'd3;
    localparam logic [2:0] SEL_J = 3'd4;

    logic clk;
    logic reset;
    logic flush;
    int   total;
    int   bad;

    riscv_soft_decode_stage_if #(.XPR_LEN(32)) bus ();

    riscv_soft_decode_stage #(
        .XPR_LEN (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [2:0] sel, input logic uses, input logic rdw, input logic ill);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".pc"}, 64'(bus.out_pc), 64'(pc));
        chk({tag, ".inst"}, 64'(bus.out_inst), 64'(inst));
        chk({tag, ".imm_sel"}, 64'(bus.out_imm_sel), 64'(sel));
        chk({tag, ".uses_imm"}, 64'(bus.out_uses_imm), 64'(uses));
        chk({tag, ".rd_wen"}, 64'(bus.out_rd_wen), 64'(rdw));
        chk({tag, ".illegal"}, 64'(bus.out_illegal), 64'(ill));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, ".inst"}, 64'(bus.out_inst), 64'd0);
        chk({tag, ".pc"}, 64'(bus.out_pc), 64'd0);
        chk({tag, ".imm_sel"}, 64'(bus.out_imm_sel), 64'd0);
        chk({tag, ".uses_imm"}, 64'(bus.out_uses_imm), 64'd0);
        chk({tag, ".rd_wen"}, 64'(bus.out_rd_wen), 64'd0);
        chk({tag, ".illegal"}, 64'(bus.out_illegal), 64'd0);
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
    endtask

    task automatic one(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [2:0] sel, input logic uses, input logic rdw, input logic ill);
        send(inst, pc);
        tick();
        bus.in_valid = 1'b0;
        chk_out(tag, pc, inst, sel, uses, rdw, ill);
        tick();
        chk({tag, ".drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;

        one("addi_x1", 32'h00500093, 32'h100, SEL_I, 1'b1, 1'b1, 1'b0);
        one("addi_x0", 32'h00000013, 32'h104, SEL_I, 1'b1, 1'b0, 1'b0);
        one("beq",     32'hFE000EE3, 32'h108, SEL_B, 1'b0, 1'b0, 1'b0);
        one("sw",      32'h00112223, 32'h10C, SEL_S, 1'b1, 1'b0, 1'b0);
        one("lui",     32'h000002B7, 32'h110, SEL_U, 1'b1, 1'b1, 1'b0);
        one("jal_x0",  32'h0000006F, 32'h114, SEL_J, 1'b1, 1'b0, 1'b0);
        one("add",     32'h002081B3, 32'h118, SEL_I, 1'b0, 1'b1, 1'b0);
        one("ill_7f",  32'h0000007F, 32'h11C, SEL_I, 1'b0, 1'b0, 1'b1);
        one("ill_rd",  32'h0000017F, 32'h120, SEL_I, 1'b0, 1'b0, 1'b1);
        one("ill_00",  32'h00000000, 32'h124, SEL_I, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            send(32'h00000093 | (32'(i) << 20), 32'h200 + 32'(4 * i));
            chk("stream.in_ready", 64'(bus.in_ready), 64'd1);
            tick();
            chk("stream.valid", 64'(bus.out_valid), 64'd1);
            chk("stream.pc", 64'(bus.out_pc), 64'(32'h200 + 32'(4 * i)));
            chk("stream.inst", 64'(bus.out_inst), 64'(32'h00000093 | (32'(i) << 20)));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream.end", 64'(bus.out_valid), 64'd0);

        bus.out_ready = 1'b0;
        send(32'h00A00093, 32'h300);
        chk("stall.a_ready", 64'(bus.in_ready), 64'd1);
        tick();
        send(32'h00B00093, 32'h304);
        chk("stall.b_ready", 64'(bus.in_ready), 64'd1);
        tick();
        send(32'h00C00093, 32'h308);
        chk("stall.full", 64'(bus.in_ready), 64'd0);
        chk("stall.hold_a", 64'(bus.out_pc), 64'h300);
        tick();
        chk("stall.still_full", 64'(bus.in_ready), 64'd0);
        chk_out("stall.a", 32'h300, 32'h00A00093, SEL_I, 1'b1, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk_out("stall.b", 32'h304, 32'h00B00093, SEL_I, 1'b1, 1'b1, 1'b0);
        chk("stall.drain_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk_out("stall.c", 32'h308, 32'h00C00093, SEL_I, 1'b1, 1'b1, 1'b0);
        tick();
        chk("stall.end", 64'(bus.out_valid), 64'd0);

        bus.out_ready = 1'b0;
        send(32'h00D00093, 32'h400);
        tick();
        send(32'h00E00093, 32'h404);
        tick();
        chk("flush.full", 64'(bus.in_ready), 64'd0);
        send(32'h00F00093, 32'h408);
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush.valid", 64'(bus.out_valid), 64'd0);
        chk("flush.in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush.gone", 64'(bus.out_valid), 64'd0);
        end
        one("flush.after", 32'h01000093, 32'h40C, SEL_I, 1'b1, 1'b1, 1'b0);

        bus.out_ready = 1'b0;
        send(32'h01100093, 32'h500);
        tick();
        send(32'h01200093, 32'h504);
        tick();
        bus.in_valid = 1'b0;
        chk("rst_mid.valid_before", 64'(bus.out_valid), 64'd1);
        chk("rst_mid.full_before", 64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        tick();
        chk_zero("rst_mid");
        reset = 1'b0;
        tick();
        chk("rst_mid.idle", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
